ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 28 ++
 rtl/ram_arbiter_rr_arb2.sv | 41 ++++
 rtl/ram_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter_pkg
//  Purpose  : Shared types and constants for the two-port RAM arbiter:
//             FSM state encoding and requester-index constants.
//  Config   : RAM_ARB_LOCK_EN (lock states are only used when defined)
//  Revision : 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

    // Arbiter FSM states: free arbitration, or ownership held by one requester
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // Requester indices, also used as the round-robin pointer encoding
    localparam logic REQ_IDX0 = 1'b0;
    localparam logic REQ_IDX1 = 1'b1;

    // Index of the requester that is not idx
    function automatic logic other_idx(input logic idx);
        return ~idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way round-robin arbiter. Combinational grant; a single
//             priority pointer favours the requester not granted most
//             recently. Pointer resets to favour requester 0.
//  Config   : none (RAM_ARB_LOCK_EN is handled by the parent)
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic prio;
    logic winner;

    // Grant: sole requester wins, contention resolved by the pointer
    always_comb begin
        gnt0   = req0 & (~req1 | (prio == REQ_IDX0));
        gnt1   = req1 & ~gnt0;
        winner = gnt1 ? REQ_IDX1 : REQ_IDX0;
    end

    // Pointer moves to the loser after every grant
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= REQ_IDX0;
        end else if (gnt0 | gnt1) begin
            prio <= other_idx(winner);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Arbitrates two requesters onto a single-port-style RAM with
//             separate read/write strobes. Combinational grant, 1-cycle
//             read return, optional lock (bounded ownership) feature.
//  Config   : RAM_ARB_LOCK_EN - when defined, lock0/lock1 are honoured and
//             the LOCK0/LOCK1 states with hold counter are built; when
//             undefined the arbiter is pure round-robin and the lock inputs
//             are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AWIDTH   = 8,
    parameter int DWIDTH   = 16,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata0,
    input  logic [DWIDTH-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DWIDTH-1:0] rdata0,
    output logic [DWIDTH-1:0] rdata1,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [AWIDTH-1:0] ram_raddr,
    output logic [AWIDTH-1:0] ram_waddr,
    output logic [DWIDTH-1:0] ram_wdata,
    input  logic [DWIDTH-1:0] ram_rdata
);

    logic allow0;
    logic allow1;
    logic arb_req0;
    logic arb_req1;
    logic pend0;
    logic pend1;

`ifdef RAM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_t       state;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_inc;

    // Saturating next value of the hold counter, and per-state stall masks
    always_comb begin
        hold_inc = (hold_cnt == CNT_W'(LOCK_MAX)) ? hold_cnt : hold_cnt + CNT_W'(1);
        allow0   = (state != LOCK1);
        allow1   = (state != LOCK0);
    end

    // Lock FSM: enter on a locked grant, leave on unlock, idle owner or hold limit
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            hold_cnt <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (gnt0 && lock0 && (LOCK_MAX > 1)) begin
                        state    <= LOCK0;
                        hold_cnt <= CNT_W'(1);
                    end else if (gnt1 && lock1 && (LOCK_MAX > 1)) begin
                        state    <= LOCK1;
                        hold_cnt <= CNT_W'(1);
                    end else begin
                        hold_cnt <= '0;
                    end
                end
                LOCK0: begin
                    if (!req0) begin
                        state    <= ARB;
                        hold_cnt <= '0;
                    end else if (gnt0) begin
                        hold_cnt <= hold_inc;
                        if (!lock0 || (hold_inc == CNT_W'(LOCK_MAX))) begin
                            state <= ARB;
                        end
                    end
                end
                LOCK1: begin
                    if (!req1) begin
                        state    <= ARB;
                        hold_cnt <= '0;
                    end else if (gnt1) begin
                        hold_cnt <= hold_inc;
                        if (!lock1 || (hold_inc == CNT_W'(LOCK_MAX))) begin
                            state <= ARB;
                        end
                    end
                end
                default: begin
                    state    <= ARB;
                    hold_cnt <= '0;
                end
            endcase
        end
    end
`else
    logic unused_lock;

    // Without the lock feature both requesters always compete
    always_comb begin
        allow0      = 1'b1;
        allow1      = 1'b1;
        unused_lock = lock0 | lock1;
    end
`endif

    // Requests seen by the arbiter: masked by lock ownership and by reset
    always_comb begin
        arb_req0 = req0 & allow0 & ~rst;
        arb_req1 = req1 & allow1 & ~rst;
    end

    rr_arb2 u_rr_arb2 (
        .clk  (clk),
        .rst  (rst),
        .req0 (arb_req0),
        .req1 (arb_req1),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    // Steer the winning requester onto the RAM strobes; idle bus is all zero
    always_comb begin
        ram_rd    = 1'b0;
        ram_wr    = 1'b0;
        ram_raddr = '0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (gnt0) begin
            if (we0) begin
                ram_wr    = 1'b1;
                ram_waddr = addr0;
                ram_wdata = wdata0;
            end else begin
                ram_rd    = 1'b1;
                ram_raddr = addr0;
            end
        end else if (gnt1) begin
            if (we1) begin
                ram_wr    = 1'b1;
                ram_waddr = addr1;
                ram_wdata = wdata1;
            end else begin
                ram_rd    = 1'b1;
                ram_raddr = addr1;
            end
        end
    end

    // Remember who issued a read so the data return is tagged next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
        end else begin
            pend0 <= gnt0 & ~we0;
            pend1 <= gnt1 & ~we1;
        end
    end

    // Reset suppresses a return that was in flight when reset arrived
    always_comb begin
        rvalid0 = pend0 & ~rst;
        rvalid1 = pend1 & ~rst;
        rdata0  = ram_rdata;
        rdata1  = ram_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Scoreboard bench for ram_arbiter. Directed stimulus pushes
//             cycle-stamped expected grants and read returns; a monitor
//             pops and compares whenever the DUT grants or returns data.
//  Config   : RAM_ARB_LOCK_EN selects the lock scenario
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic        ram_rd, ram_wr;
    logic [7:0]  ram_raddr, ram_waddr;
    logic [15:0] ram_wdata, ram_rdata;

    ram_arbiter #(.AWIDTH(8), .DWIDTH(16), .LOCK_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_raddr(ram_raddr),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    typedef struct { int cyc; logic [35:0] v; } gexp_t;
    typedef struct { int cyc; logic [17:0] v; } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;

    logic [15:0] mem [256];
    logic [35:0] gvec;
    logic [17:0] rvec;

    assign gvec = {gnt0, gnt1, ram_rd, ram_wr, ram_raddr, ram_waddr, ram_wdata};
    assign rvec = {rvalid0, rvalid1, (rvalid1 ? rdata1 : rdata0)};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: 1-cycle registered read, write on the edge
    always @(posedge clk) begin
        if (cyc == 0) begin
            mem[8'h10] <= 16'h1234;
            mem[8'h30] <= 16'hA0A0;
            mem[8'h31] <= 16'hB1B1;
            mem[8'h20] <= 16'h0000;
        end
        if (ram_wr) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= ram_rd ? mem[ram_raddr] : 16'h0000;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare whenever the DUT grants or returns read data
    always @(negedge clk) begin
        gexp_t ge;
        rexp_t re;
        if (gnt0 | gnt1 | ram_rd | ram_wr) begin
            if (gq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL grant_unexpected @cycle %0d: got %h expected none", cyc, gvec);
            end else begin
                ge = gq.pop_front();
                check("grant", 64'({cyc[15:0], gvec}), 64'({ge.cyc[15:0], ge.v}));
            end
        end else begin
            check("idle_bus", 64'({ram_raddr, ram_waddr, ram_wdata}), 64'd0);
        end
        if (rvalid0 | rvalid1) begin
            if (rq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rvalid_unexpected @cycle %0d: got %h expected none", cyc, rvec);
            end else begin
                re = rq.pop_front();
                check("rvalid", 64'({cyc[15:0], rvec}), 64'({re.cyc[15:0], re.v}));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic r0, input logic w0, input logic [7:0] a0,
                       input logic [15:0] d0, input logic l0,
                       input logic r1, input logic w1, input logic [7:0] a1,
                       input logic [15:0] d1, input logic l1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
    endtask

    task automatic idle();
        drv(0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0, 0);
    endtask

    // Expected grant this cycle
    task automatic eg(input int who, input logic we, input logic [7:0] a, input logic [15:0] d);
        gexp_t e;
        e.cyc = cyc;
        e.v   = {(who == 0), (who == 1), ~we, we,
                 (we ? 8'h00 : a), (we ? a : 8'h00), (we ? d : 16'h0000)};
        gq.push_back(e);
    endtask

    // Expected read return next cycle
    task automatic er(input int who, input logic [15:0] d);
        rexp_t e;
        e.cyc = cyc + 1;
        e.v   = {(who == 0), (who == 1), d};
        rq.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drv(1, 0, 8'h10, 16'h0, 1, 1, 0, 8'h31, 16'h0, 1);
        // Reset with both requesting: everything quiet
        step(); #3 check("rst_outputs", 64'({gnt0, gnt1, ram_rd, ram_wr, rvalid0, rvalid1}), 64'd0);
        step(); #3 check("rst_outputs", 64'({gnt0, gnt1, ram_rd, ram_wr, rvalid0, rvalid1}), 64'd0);
        step(); rst = 1'b0; idle();

        // Single read, 1-cycle return
        step(); drv(1, 0, 8'h10, 16'h0, 0, 0, 0, 8'h00, 16'h0, 0);
        eg(0, 0, 8'h10, 16'h0); er(0, 16'h1234);
        step(); idle();
        step(); drv(0, 0, 8'h00, 16'h0, 0, 1, 0, 8'h10, 16'h0, 0);
        eg(1, 0, 8'h10, 16'h0); er(1, 16'h1234);

        // Contention: strict alternation 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            step(); drv(1, 0, 8'h30, 16'h0, 0, 1, 0, 8'h31, 16'h0, 0);
            if (i % 2 == 0) begin eg(0, 0, 8'h30, 16'h0); er(0, 16'hA0A0); end
            else            begin eg(1, 0, 8'h31, 16'h0); er(1, 16'hB1B1); end
        end

        // Write by 1 then read-back by 0
        step(); drv(0, 0, 8'h00, 16'h0, 0, 1, 1, 8'h20, 16'hBEEF, 0);
        eg(1, 1, 8'h20, 16'hBEEF);
        step(); drv(1, 0, 8'h20, 16'h0, 0, 0, 0, 8'h00, 16'h0, 0);
        eg(0, 0, 8'h20, 16'h0); er(0, 16'hBEEF);

        // Back-to-back reads from one requester
        step(); drv(1, 0, 8'h30, 16'h0, 0, 0, 0, 8'h00, 16'h0, 0);
        eg(0, 0, 8'h30, 16'h0); er(0, 16'hA0A0);
        step(); drv(1, 0, 8'h10, 16'h0, 0, 0, 0, 8'h00, 16'h0, 0);
        eg(0, 0, 8'h10, 16'h0); er(0, 16'h1234);
        step(); drv(0, 0, 8'h00, 16'h0, 0, 1, 0, 8'h31, 16'h0, 0);
        eg(1, 0, 8'h31, 16'h0); er(1, 16'hB1B1);

`ifdef RAM_ARB_LOCK_EN
        // Locked owner for LOCK_MAX grants, then the other side gets one
        for (int i = 0; i < 6; i++) begin
            step(); drv(1, 0, 8'h30, 16'h0, 1, 1, 0, 8'h31, 16'h0, 0);
            if (i == 4) begin eg(1, 0, 8'h31, 16'h0); er(1, 16'hB1B1); end
            else        begin eg(0, 0, 8'h30, 16'h0); er(0, 16'hA0A0); end
        end
        step(); idle();
        step(); drv(0, 0, 8'h00, 16'h0, 0, 1, 0, 8'h31, 16'h0, 0);
        eg(1, 0, 8'h31, 16'h0); er(1, 16'hB1B1);
`else
        // Lock inputs ignored: alternation continues
        for (int i = 0; i < 4; i++) begin
            step(); drv(1, 0, 8'h30, 16'h0, 1, 1, 0, 8'h31, 16'h0, 0);
            if (i % 2 == 0) begin eg(0, 0, 8'h30, 16'h0); er(0, 16'hA0A0); end
            else            begin eg(1, 0, 8'h31, 16'h0); er(1, 16'hB1B1); end
        end
`endif

        // Read granted, then reset: no return; after release 0 wins first
        step(); drv(1, 0, 8'h10, 16'h0, 0, 0, 0, 8'h00, 16'h0, 0);
        eg(0, 0, 8'h10, 16'h0);
        step(); rst = 1'b1; drv(1, 0, 8'h30, 16'h0, 0, 1, 0, 8'h31, 16'h0, 0);
        #3 check("rst_kills_rvalid", 64'({rvalid0, rvalid1}), 64'd0);
        check("rst_outputs", 64'({gnt0, gnt1, ram_rd, ram_wr}), 64'd0);
        step(); #3 check("rst_outputs", 64'({gnt0, gnt1, ram_rd, ram_wr, rvalid0, rvalid1}), 64'd0);
        step(); rst = 1'b0; drv(1, 0, 8'h30, 16'h0, 0, 1, 0, 8'h31, 16'h0, 0);
        eg(0, 0, 8'h30, 16'h0); er(0, 16'hA0A0);
        step(); drv(1, 0, 8'h30, 16'h0, 0, 1, 0, 8'h31, 16'h0, 0);
        eg(1, 0, 8'h31, 16'h0); er(1, 16'hB1B1);

        step(); idle();
        step();
        step();
        #3;
        check("grant_queue_drained", 64'(gq.size()), 64'd0);
        check("rvalid_queue_drained", 64'(rq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
